alu_op_arbiter: RTL
===================

Name: alu_op_arbiter

Overview:
- Sequential front-end that shares one combinational ALU operation unit between two requesters.
- Operations: inverted-shift-right, shift-left, AND, XOR.
- Arbitrates requests round-robin, captures the accepted operands, computes the result in one registered cycle and holds it until the consumer takes it.
- Sits between requester logic (e.g. test controller, sequencer) and the result/status register path of the ALU top level.

Parameters:
- M, 8, operand width in bits (i_arg_A, i_arg_B).
- K, 8, result width in bits (o_result); K >= M required.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  2  request valid, bit i = requester i.
- o_req_ready  output  2  request accepted this cycle, bit i = requester i.
- i_op  input  2x2  opcode per requester (i_op[i]).
- i_arg_A  input  2xM  operand A per requester.
- i_arg_B  input  2xM  operand B per requester.
- o_valid  output  1  result valid.
- i_resp_ready  input  1  consumer takes result.
- o_id  output  1  requester index that owns the result.
- o_result  output  K  operation result.
- o_status  output  4  [3] invalid argument, [2:1] reserved 0, [0] zero result.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_valid=0, o_req_ready=0, o_id=0, o_result=0, o_status=0, RR pointer=0 (requester 0 has priority).
- States: IDLE, EXEC, RESP.
- IDLE:
  - o_req_ready is combinational, one-hot or zero.
  - Grant goes to the pointer requester if valid, else the other if valid.
  - On grant: latch op/A/B/id, pointer <= ~granted id, go to EXEC.
  - No valid request: stay in IDLE.
- EXEC:
  - o_req_ready=0.
  - Sub-module result/status registered into o_result/o_status/o_id.
  - o_valid <= 1, go to RESP.
- RESP:
  - o_valid=1; outputs stable until i_resp_ready=1.
  - On i_resp_ready: o_valid <= 0, go to IDLE.
  - No same-cycle re-accept. Throughput is 1 op per 3 cycles minimum.
- Latency: accept at cycle N, o_valid high from cycle N+2.
- Operations (A, B unsigned; result zero-extended to K):
  - 2'b00 RSHN: error if B[M-1]==0. Otherwise result = A >> (~B). Shift amounts >= M give 0.
  - 2'b01 LSH: error if B >= M. Otherwise result = (A << B) truncated to M bits.
  - 2'b10 AND: A & B, never errors.
  - 2'b11 XOR: A ^ B, never errors.
- Error: status = 4'b1000, result = 0 (never X).
- No error: status[0] = (result == 0), other bits 0.
- Both requesters valid: pointer decides; the loser keeps waiting. A requester must hold valid and operands stable until ready.
- Valid dropped before grant: no effect, no state change.
- Reset mid-operation: everything returns to reset values immediately; the in-flight request is lost and is not replayed.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic[1:0] op_e {OP_RSHN, OP_LSH, OP_AND, OP_XOR}.
  - typedef enum state_e {S_IDLE, S_EXEC, S_RESP}.
  - Status constants ST_OK=4'b0000, ST_ERR=4'b1000, ST_ZERO=4'b0001.
- One combinational sub-module alu_op_unit (inputs: op, A, B; outputs: result, status) contains all operation and error logic.
- alu_op_arbiter contains only the FSM, arbitration and registers.

Test Plan:
- Reset then req0 RSHN, A=8'hF0, B=8'hFD -> o_req_ready=2'b01 same cycle; two cycles later o_valid=1, o_result=8'h3C, o_status=4'b0000, o_id=0.
- req1 RSHN, A=8'hF0, B=8'h02 -> o_result=8'h00, o_status=4'b1000. Separately, LSH with B=8'h08 -> o_status=4'b1000.
- Both valid continuously, AND A=8'h0F B=8'h0F (req0), XOR same operands (req1):
  - Grants alternate 0,1,0,1.
  - Results 8'h0F status 0000 / 8'h00 status 0001.
- Backpressure: hold i_resp_ready=0 for 5 cycles in RESP -> o_valid, o_result, o_id stable and o_req_ready=0 throughout; ready=1 -> o_valid drops next cycle.
- Assert i_rst_n=0 during EXEC and during RESP -> all outputs 0 asynchronously (before next edge). After release, a req1-only request is granted first time.
- LSH A=8'h81 B=8'h01 -> o_result=8'h02, o_status=4'b0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation arbiter and its operation unit.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_RSHN = 2'b00,
    OP_LSH  = 2'b01,
    OP_AND  = 2'b10,
    OP_XOR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

  localparam logic [3:0] ST_OK   = 4'b0000;
  localparam logic [3:0] ST_ERR  = 4'b1000;
  localparam logic [3:0] ST_ZERO = 4'b0001;

  // Status for a non-error result: only the zero flag can be set.
  function automatic logic [3:0] ok_status(input logic is_zero);
    return is_zero ? ST_ZERO : ST_OK;
  endfunction

endpackage

// File: rtl/alu_op_unit.sv
// Combinational operation unit: computes result and status for one operation,
// including argument checking. Errors force a zero result.
module alu_op_unit
  import alu_pkg::*;
#(
  parameter int unsigned M = 8,
  parameter int unsigned K = 8
) (
  input  op_e          op_i,
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  output logic [K-1:0] result_o,
  output logic [3:0]   status_o
);

  localparam logic [M:0] OperandWidth = (M+1)'(M);

  logic [M-1:0] res;
  logic         err;

  always_comb begin
    res = '0;
    err = 1'b0;
    unique case (op_i)
      OP_RSHN: begin
        // Shift amount is the complement of B; a clear MSB means an invalid request.
        err = ~b_i[M-1];
        res = err ? '0 : (a_i >> (~b_i));
      end
      OP_LSH: begin
        err = ({1'b0, b_i} >= OperandWidth);
        res = err ? '0 : (a_i << b_i);
      end
      OP_AND: res = a_i & b_i;
      OP_XOR: res = a_i ^ b_i;
    endcase
  end

  always_comb begin
    result_o = K'(res);
    status_o = err ? ST_ERR : ok_status(res == '0);
  end

endmodule

// File: rtl/alu_op_arbiter.sv
// Round-robin front-end sharing one alu_op_unit between two requesters:
// accept in IDLE, compute in EXEC, hold the registered result in RESP.
module alu_op_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned M = 8,
  parameter int unsigned K = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_req_valid,
  output logic [1:0]          o_req_ready,
  input  logic [1:0][1:0]     i_op,
  input  logic [1:0][M-1:0]   i_arg_A,
  input  logic [1:0][M-1:0]   i_arg_B,
  output logic                o_valid,
  input  logic                i_resp_ready,
  output logic                o_id,
  output logic [K-1:0]        o_result,
  output logic [3:0]          o_status
);

  state_e       state_q;
  logic         ptr_q;
  op_e          op_q;
  logic [M-1:0] a_q;
  logic [M-1:0] b_q;
  logic         id_q;

  logic [1:0]   grant;
  logic         grant_id;
  logic [K-1:0] unit_result;
  logic [3:0]   unit_status;

  // Pointer requester wins when valid; otherwise the other one may take the slot.
  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    if (state_q == S_IDLE) begin
      if (i_req_valid[ptr_q]) begin
        grant_id = ptr_q;
        grant    = ptr_q ? 2'b10 : 2'b01;
      end else if (i_req_valid[~ptr_q]) begin
        grant_id = ~ptr_q;
        grant    = ptr_q ? 2'b01 : 2'b10;
      end
    end
  end

  // Held low during reset so a request can never appear accepted while in reset.
  assign o_req_ready = grant & {2{i_rst_n}};

  alu_op_unit #(
    .M(M),
    .K(K)
  ) u_op_unit (
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .result_o(unit_result),
    .status_o(unit_status)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      op_q     <= OP_RSHN;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      o_valid  <= 1'b0;
      o_id     <= 1'b0;
      o_result <= '0;
      o_status <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|grant) begin
            op_q    <= op_e'(i_op[grant_id]);
            a_q     <= i_arg_A[grant_id];
            b_q     <= i_arg_B[grant_id];
            id_q    <= grant_id;
            ptr_q   <= ~grant_id;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          o_result <= unit_result;
          o_status <= unit_status;
          o_id     <= id_q;
          o_valid  <= 1'b1;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          if (i_resp_ready) begin
            o_valid <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
